main: RTL and testbench

- Synchronous modulo-N up-counter, default N = 4, with a 4-bit count output.
- Counts 0,1,…,N-1 and wraps to 0, advancing on every rising clock edge while not in reset.
- Used as a small free-running sequencer/timebase leaf block; no handshake, no enable.
- Built as a synchronous (common-clock) counter of toggle-flop bit slices, not a ripple counter.

---
 rtl/main_pkg.sv | 12 +
 rtl/main_counter_tff_slice.sv | 27 ++
 rtl/main.sv | 50 +++++
 tb/tb_main.sv | 128 ++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared constants and types for the modulo-N counter.
//   DEFAULT_WIDTH   : default bit width of the count
//   DEFAULT_MODULUS : default number of states in the count sequence
//   count_t         : count word at the default width
package main_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_MODULUS = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : main_pkg

// File: rtl/main_counter_tff_slice.sv
// One-bit synchronous toggle flop used as a counter bit slice.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (highest priority)
//   t   : toggle request
//   clr : synchronous clear (beats toggle)
//   q   : registered bit value
module counter_tff_slice (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic clr,
  output logic q
);

  // Priority: rst, then clr, then t.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule : counter_tff_slice

// File: rtl/main.sv
// Free-running synchronous modulo-MODULUS up-counter built from toggle-flop
// bit slices sharing one clock.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   count : registered counter state, 0..MODULUS-1
module main
  import main_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  // Reject moduli that cannot be represented or would never count.
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $fatal(1, "main: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_COUNT = WIDTH'(MODULUS - 1);

  // Increment enable; the counter has no external enable so it is always on.
  localparam logic INC_EN = 1'b1;

  logic [WIDTH-1:0] w_toggle;
  logic             w_wrap;

  // Terminal-count decode; >= also pulls any out-of-range state back to 0.
  assign w_wrap = (count >= TERM_COUNT);

  // Carry chain: bit i toggles when the enable and all lower bits are 1.
  assign w_toggle[0] = INC_EN;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
    assign w_toggle[gi] = w_toggle[gi-1] & count[gi-1];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    counter_tff_slice u_slice (
      .clk (clk),
      .rst (rst),
      .t   (w_toggle[gi]),
      .clr (w_wrap),
      .q   (count[gi])
    );
  end

endmodule : main

// File: tb/tb_main.sv
// Self-checking bench for main: three builds (MODULUS 4, 3, 16) share clock
// and reset and are compared every cycle against a modulo-arithmetic model,
// with a few directed literal checks on the default build.
module tb_main;

  logic       clk;
  logic       rst;
  logic [3:0] count4;
  logic [3:0] count3;
  logic [3:0] count16;

  int vectors;
  int miscompares;

  // Reference model: plain modulo arithmetic per build.
  int  m4;
  int  m3;
  int  m16;
  bit  mvalid;

  main #(.WIDTH(4), .MODULUS(4))  u_dut4  (.clk(clk), .rst(rst), .count(count4));
  main #(.WIDTH(4), .MODULUS(3))  u_dut3  (.clk(clk), .rst(rst), .count(count3));
  main #(.WIDTH(4), .MODULUS(16)) u_dut16 (.clk(clk), .rst(rst), .count(count16));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge; rst is only ever changed off-edge.
  always @(posedge clk) begin
    if (rst) begin
      m4 = 0; m3 = 0; m16 = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      m4  = (m4 + 1) % 4;
      m3  = (m3 + 1) % 3;
      m16 = (m16 + 1) % 16;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (mvalid) begin
      check("mod4", int'(count4), m4);
      check("mod3", int'(count3), m3);
      check("mod16", int'(count16), m16);
      check("mod4_upper_bits", int'(count4[3:2]), 0);
    end
  end

  initial begin
    int budget;
    vectors     = 0;
    miscompares = 0;
    mvalid      = 1'b0;
    m4 = 0; m3 = 0; m16 = 0;
    rst = 1'b1;

    // Reset hold for three edges.
    @(posedge clk); #1;
    check("reset_first_edge", int'(count4), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold", int'(count4), 0);
    check("reset_hold_m16", int'(count16), 0);

    // Release between edges; nothing may change until the next edge.
    @(negedge clk); #2;
    rst = 1'b0;
    #3;
    check("no_change_off_edge", int'(count4), 0);
    @(posedge clk); #1;
    check("release_latency", int'(count4), 1);
    check("release_m3", int'(count3), 1);
    @(posedge clk); #1;
    check("seq_2", int'(count4), 2);
    check("m3_seq_2", int'(count3), 2);
    @(posedge clk); #1;
    check("seq_3", int'(count4), 3);
    check("m3_wrap", int'(count3), 0);
    check("m16_seq_3", int'(count16), 3);
    @(posedge clk); #1;
    check("wrap_3_to_0", int'(count4), 0);
    check("m16_seq_4", int'(count16), 4);

    // Free run: 21 more edges (25 total since release).
    repeat (21) @(posedge clk);
    #1;
    check("free_run_25", int'(count4), 25 % 4);
    check("m16_free_run_25", int'(count16), 25 % 16);

    // Reset mid-count at count==2, with a bounded wait.
    budget = 8;
    while (count4 != 4'd2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("reach_count_2", int'(count4), 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset", int'(count4), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("resume_after_reset", int'(count4), 1);

    // Randomized reset activity, roughly one edge in sixteen.
    repeat (2000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_main
